// File: rtl/sipo_deser_pkg.sv
// Shared constants for the serial-to-parallel deserializer slice.
package sipo_deser_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 4;

    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Shift register and bit counter; flags the bit that completes a word.
module sipo_shreg
    import sipo_deser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter bit          MSB_FIRST  = ORDER_MSB_FIRST,
    localparam int unsigned CNT_W     = cnt_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  acc,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] shreg,
    output logic [DATA_WIDTH-1:0] nxt_c,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic                  last_c
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    // Shifted value including the incoming bit, in the configured bit order
    always_comb begin
        nxt_c = shreg;
        if (MSB_FIRST) begin
            nxt_c = {shreg[DATA_WIDTH-2:0], bit_in};
        end else begin
            nxt_c = {bit_in, shreg[DATA_WIDTH-1:1]};
        end
        last_c = acc && (bit_cnt == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (acc) begin
            shreg   <= nxt_c;
            bit_cnt <= last_c ? '0 : bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with one pending word behind the output slot.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter bit          MSB_FIRST  = ORDER_MSB_FIRST,
    localparam int unsigned CNT_W     = cnt_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  s_in,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] p_out,
    output logic                  p_valid,
    input  logic                  p_ready,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic                  overrun
);

    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] nxt_c;
    logic                  last_c;
    logic                  pend;
    logic                  acc;
    logic                  pop;
    logic                  slot_free;

    // s_ready is kept as the flop itself; pend is simply its complement
    assign pend      = !s_ready;
    assign acc       = s_valid && s_ready;
    assign pop       = p_valid && p_ready;
    assign slot_free = !p_valid || p_ready;

    sipo_shreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .acc     (acc),
        .bit_in  (s_in),
        .shreg   (shreg),
        .nxt_c   (nxt_c),
        .bit_cnt (bit_cnt),
        .last_c  (last_c)
    );

    // Output slot: pending word has priority; a completing word bypasses shreg when the slot frees
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready <= 1'b1;
            p_out   <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (clr) begin
            s_ready <= 1'b1;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (s_valid && !s_ready) begin
                overrun <= 1'b1;
            end
            if (pend && slot_free) begin
                p_out   <= shreg;
                p_valid <= 1'b1;
                s_ready <= 1'b1;
            end else if (last_c && slot_free) begin
                p_out   <= nxt_c;
                p_valid <= 1'b1;
            end else begin
                if (last_c) begin
                    s_ready <= 1'b0;
                end
                if (pop) begin
                    p_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: both bit orders driven in parallel against a word-queue model.
module tb_sipo_deser;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic s_in = 1'b0;
    logic s_valid = 1'b0;
    logic p_ready = 1'b0;

    logic         s_ready_m, s_ready_l;
    logic [W-1:0] p_out_m, p_out_l;
    logic         p_valid_m, p_valid_l;
    logic [1:0]   bit_cnt_m, bit_cnt_l;
    logic         overrun_m, overrun_l;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    sipo_deser #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .clr(clr), .s_in(s_in), .s_valid(s_valid),
        .s_ready(s_ready_m), .p_out(p_out_m), .p_valid(p_valid_m),
        .p_ready(p_ready), .bit_cnt(bit_cnt_m), .overrun(overrun_m)
    );

    sipo_deser #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .clr(clr), .s_in(s_in), .s_valid(s_valid),
        .s_ready(s_ready_l), .p_out(p_out_l), .p_valid(p_valid_l),
        .p_ready(p_ready), .bit_cnt(bit_cnt_l), .overrun(overrun_l)
    );

    // Model: accepted bits of the partial word, plus a queue of up to two finished words
    logic         pbits[$];
    logic [W-1:0] wm[$];
    logic [W-1:0] wl[$];
    logic [W-1:0] mpm = '0;
    logic [W-1:0] mpl = '0;
    logic         movr = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pbits.delete();
            wm.delete();
            wl.delete();
            mpm  = '0;
            mpl  = '0;
            movr = 1'b0;
        end else if (clr) begin
            pbits.delete();
            wm.delete();
            wl.delete();
            movr = 1'b0;
        end else begin : upd
            bit           full;
            logic [W-1:0] m;
            logic [W-1:0] l;
            full = (wm.size() == 2);
            if (s_valid && full) movr = 1'b1;
            if (p_ready && wm.size() > 0) begin
                void'(wm.pop_front());
                void'(wl.pop_front());
            end
            if (s_valid && !full) begin
                pbits.push_back(s_in);
                if (pbits.size() == W) begin
                    m = '0;
                    l = '0;
                    for (int i = 0; i < W; i++) begin
                        m[W-1-i] = pbits[i];
                        l[i]     = pbits[i];
                    end
                    wm.push_back(m);
                    wl.push_back(l);
                    pbits.delete();
                end
            end
            if (wm.size() > 0) begin
                mpm = wm[0];
                mpl = wl[0];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        if (started) begin
            chk("p_valid_m", 32'(p_valid_m), 32'(wm.size() > 0));
            chk("p_valid_l", 32'(p_valid_l), 32'(wl.size() > 0));
            chk("s_ready_m", 32'(s_ready_m), 32'(wm.size() < 2));
            chk("s_ready_l", 32'(s_ready_l), 32'(wl.size() < 2));
            chk("bit_cnt_m", 32'(bit_cnt_m), 32'(pbits.size()));
            chk("bit_cnt_l", 32'(bit_cnt_l), 32'(pbits.size()));
            chk("overrun_m", 32'(overrun_m), 32'(movr));
            chk("overrun_l", 32'(overrun_l), 32'(movr));
            chk("p_out_m", 32'(p_out_m), 32'(mpm));
            chk("p_out_l", 32'(p_out_l), 32'(mpl));
        end
    end

    task automatic cyc(input logic v, input logic b, input logic pr);
        s_valid = v;
        s_in    = b;
        p_ready = pr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0);
        started = 1'b1;
        cyc(0, 0, 0);
        chk("rst_p_valid", 32'(p_valid_m), 32'h0);
        chk("rst_p_out", 32'(p_out_m), 32'h0);
        rst = 1'b1;
        cyc(0, 0, 1);
        chk("rel_s_ready", 32'(s_ready_m), 32'h1);
        chk("rel_bit_cnt", 32'(bit_cnt_m), 32'h0);

        // MSB-first word 1,0,1,1
        cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 1, 1);
        chk("t1_bit_cnt", 32'(bit_cnt_m), 32'h3);
        cyc(1, 1, 1);
        chk("t1_p_valid", 32'(p_valid_m), 32'h1);
        chk("t1_p_out_m", 32'(p_out_m), 32'hB);
        chk("t1_p_out_l", 32'(p_out_l), 32'hD);
        cyc(0, 0, 1);
        chk("t1_drop", 32'(p_valid_m), 32'h0);

        // LSB-first back-to-back words
        cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
        chk("t2_w1", 32'(p_out_l), 32'h1);
        cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 1, 1);
        chk("t2_w2", 32'(p_out_l), 32'h8);
        chk("t2_valid", 32'(p_valid_l), 32'h1);
        cyc(0, 0, 1);

        // Backpressure: 1111 then 0101 with the consumer stalled
        for (int i = 0; i < 4; i++) cyc(1, 1, 0);
        cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
        chk("t3_hold", 32'(p_out_m), 32'hF);
        chk("t3_s_ready", 32'(s_ready_m), 32'h0);
        cyc(0, 0, 1);
        chk("t3_next", 32'(p_out_m), 32'h5);
        chk("t3_valid", 32'(p_valid_m), 32'h1);
        chk("t3_ready_back", 32'(s_ready_m), 32'h1);

        // Overrun: fill pending slot, then push bits that must be dropped
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        cyc(1, 1, 0); cyc(1, 1, 0);
        chk("t4_overrun", 32'(overrun_m), 32'h1);
        chk("t4_cnt", 32'(bit_cnt_m), 32'h0);
        cyc(0, 0, 1);
        chk("t4_pend_word", 32'(p_out_m), 32'h3);
        cyc(0, 0, 1);
        cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 1, 1);
        chk("t4_clean_word", 32'(p_out_m), 32'h9);
        chk("t4_sticky", 32'(overrun_m), 32'h1);
        clr = 1'b1;
        cyc(1, 1, 1);
        clr = 1'b0;
        chk("t4_clr_ovr", 32'(overrun_m), 32'h0);
        chk("t4_clr_cnt", 32'(bit_cnt_m), 32'h0);
        chk("t4_clr_valid", 32'(p_valid_m), 32'h0);
        chk("t4_clr_pout", 32'(p_out_m), 32'h9);

        // Mid-word asynchronous reset
        cyc(1, 1, 1); cyc(1, 1, 1);
        chk("t5_cnt2", 32'(bit_cnt_m), 32'h2);
        s_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_pout", 32'(p_out_m), 32'h0);
        chk("t5_rst_valid", 32'(p_valid_m), 32'h0);
        chk("t5_rst_cnt", 32'(bit_cnt_m), 32'h0);
        chk("t5_rst_ovr", 32'(overrun_m), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(0, 0, 1);
        cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 1, 1); cyc(1, 0, 1);
        chk("t5_word", 32'(p_out_m), 32'h6);

        // Gapped input; s_in toggles on gaps and must be ignored
        cyc(1, 1, 1);
        cyc(0, 1, 1);
        chk("t6_gap1", 32'(bit_cnt_m), 32'h1);
        cyc(1, 0, 1);
        cyc(0, 1, 1); cyc(0, 1, 1);
        chk("t6_gap2", 32'(bit_cnt_m), 32'h2);
        cyc(1, 1, 1); cyc(1, 1, 1);
        chk("t6_word", 32'(p_out_m), 32'hB);
        chk("t6_valid", 32'(p_valid_m), 32'h1);
        cyc(0, 0, 1);
        chk("t6_once", 32'(p_valid_m), 32'h0);
        cyc(0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
